// File: rtl/dco_ctrl_pkg.sv
// dco_ctrl_pkg: state encoding, datapath widths and saturation limits for the DCO lock loop
package dco_ctrl_pkg;
  localparam int CW = 16;
  localparam int EW = 17;
  localparam int IW = 24;
  localparam int SW = 25;
  localparam logic signed [IW-1:0] INTEG_MAX = 24'sh7FFFFF;
  localparam logic signed [IW-1:0] INTEG_MIN = 24'sh800001;
  localparam logic signed [CW-1:0] CTRL_MAX = 16'sh7FFF;
  localparam logic signed [CW-1:0] CTRL_MIN = 16'sh8000;
  localparam logic signed [SW-1:0] INTEG_MAX_S = 25'sd8388607;
  localparam logic signed [SW-1:0] INTEG_MIN_S = -25'sd8388607;
  localparam logic signed [SW-1:0] CTRL_MAX_S = 25'sd32767;
  localparam logic signed [SW-1:0] CTRL_MIN_S = -25'sd32768;
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, UPDATE} state_t;
endpackage

// File: rtl/dco_pi_core.sv
// dco_pi_core: combinational PI arithmetic -- error, saturating integrator, saturated control word
module dco_pi_core
  import dco_ctrl_pkg::*;
#(
  parameter int KP_SHIFT = 2,
  parameter int KI_SHIFT = 4
) (
  input  logic        [CW-1:0] target,
  input  logic        [CW-1:0] meas_count,
  input  logic signed [EW-1:0] err_in,
  input  logic signed [IW-1:0] integ,
  output logic signed [EW-1:0] err,
  output logic signed [IW-1:0] integ_next,
  output logic signed [CW-1:0] ctrl_next
);
  logic signed [SW-1:0] isum, csum;
  logic signed [EW-1:0] p_term;
  logic signed [IW-1:0] i_term;
  assign err = $signed({1'b0, target}) - $signed({1'b0, meas_count});
  assign isum = {integ[IW-1], integ} + {{(SW-EW){err_in[EW-1]}}, err_in};
  assign integ_next = isum > INTEG_MAX_S ? INTEG_MAX : isum < INTEG_MIN_S ? INTEG_MIN : isum[IW-1:0];
  assign p_term = err_in >>> KP_SHIFT;
  assign i_term = integ_next >>> KI_SHIFT;
  assign csum = {{(SW-EW){p_term[EW-1]}}, p_term} + {i_term[IW-1], i_term};
  assign ctrl_next = csum > CTRL_MAX_S ? CTRL_MAX : csum < CTRL_MIN_S ? CTRL_MIN : csum[CW-1:0];
endmodule

// File: rtl/dco_lock_ctrl.sv
// dco_lock_ctrl: settle/measure/update FSM that locks a DCO to a target edge count via a PI loop.
// Define DCO_LOCK_CTRL_LOSS_DETECT_EN to drop locked on an out-of-tolerance measurement.
module dco_lock_ctrl
  import dco_ctrl_pkg::*;
#(
  parameter int KP_SHIFT      = 2,
  parameter int KI_SHIFT      = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_TOL      = 4,
  parameter int LOCK_COUNT    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic        [CW-1:0] target,
  input  logic                 meas_valid,
  input  logic        [CW-1:0] meas_count,
  output logic                 meas_ready,
  output logic                 dco_enable,
  output logic signed [CW-1:0] dco_control,
  output logic                 locked,
  output logic                 busy
);
  localparam int STW = $clog2(SETTLE_CYCLES + 1);
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic signed [EW-1:0] TOL = EW'(LOCK_TOL);
  state_t state;
  logic [STW-1:0] settle_cnt;
  logic [LW-1:0] lock_cnt, lock_next;
  logic signed [EW-1:0] err, err_q;
  logic signed [IW-1:0] integ, integ_next;
  logic signed [CW-1:0] ctrl_next;
  logic in_tol, locked_next;
  dco_pi_core #(.KP_SHIFT(KP_SHIFT), .KI_SHIFT(KI_SHIFT)) u_pi (
    .target(target),
    .meas_count(meas_count),
    .err_in(err_q),
    .integ(integ),
    .err(err),
    .integ_next(integ_next),
    .ctrl_next(ctrl_next)
  );
  assign busy = state != IDLE;
  assign dco_enable = busy;
  assign meas_ready = state == MEASURE;
  assign in_tol = err_q <= TOL && err_q >= -TOL;
  assign lock_next = !in_tol ? '0 : lock_cnt == LW'(LOCK_COUNT) ? lock_cnt : lock_cnt + LW'(1);
`ifdef DCO_LOCK_CTRL_LOSS_DETECT_EN
  assign locked_next = lock_next == LW'(LOCK_COUNT);
`else
  assign locked_next = locked || lock_next == LW'(LOCK_COUNT);
`endif
  // err is latched at acceptance so the update uses the target seen on that edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      lock_cnt    <= '0;
      err_q       <= '0;
      integ       <= '0;
      dco_control <= '0;
      locked      <= 1'b0;
    end else if (!start) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      lock_cnt    <= '0;
      err_q       <= '0;
      integ       <= '0;
      dco_control <= '0;
      locked      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state      <= SETTLE;
          settle_cnt <= '0;
        end
        SETTLE: begin
          if (settle_cnt == STW'(SETTLE_CYCLES - 1)) state <= MEASURE;
          else settle_cnt <= settle_cnt + STW'(1);
        end
        MEASURE: begin
          if (meas_valid) begin
            err_q <= err;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          integ       <= integ_next;
          dco_control <= ctrl_next;
          lock_cnt    <= lock_next;
          locked      <= locked_next;
          state       <= MEASURE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dco_lock_ctrl.sv
// tb_dco_lock_ctrl: vector table, hand sequences and random measurements checked against a PI model
module tb_dco_lock_ctrl;
  localparam int KP = 2;
  localparam int KI = 4;
  localparam int TOL = 4;
  localparam int LC = 3;
  localparam int IMAX = 8388607;
`ifdef DCO_LOCK_CTRL_LOSS_DETECT_EN
  localparam bit LD = 1'b1;
`else
  localparam bit LD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, meas_valid = 1'b0;
  logic [15:0] target = '0, meas_count = '0;
  logic meas_ready, dco_enable, locked, busy;
  logic signed [15:0] dco_control;
  int total = 0, passed = 0;
  int m_integ, m_ctrl, m_cnt;
  bit m_locked;
  typedef struct {
    int tgt;
    int cnt;
    int ctrl;
    bit lk;
  } vec_t;
  vec_t vecs[6];

  dco_lock_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .target(target),
    .meas_valid(meas_valid), .meas_count(meas_count), .meas_ready(meas_ready),
    .dco_enable(dco_enable), .dco_control(dco_control), .locked(locked), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return v > hi ? hi : v < lo ? lo : v;
  endfunction

  task automatic m_clear;
    m_integ = 0;
    m_ctrl = 0;
    m_cnt = 0;
    m_locked = 0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    start = 1'b0;
    meas_valid = 1'b0;
    step;
    rst = 1'b0;
    step;
    m_clear;
  endtask

  task automatic go_measure;
    start = 1'b1;
    step;
    for (int n = 0; n < 40 && !meas_ready; n++) step;
    chk("reach_measure", int'(meas_ready), 1);
  endtask

  // one accepted measurement; garbage on the inputs during UPDATE must be ignored
  task automatic do_meas(input int tgt, input int cnt);
    int e;
    target = 16'(tgt);
    meas_count = 16'(cnt);
    meas_valid = 1'b1;
    step;
    meas_valid = 1'($urandom_range(0, 1));
    meas_count = 16'($urandom);
    target = 16'($urandom);
    chk("ctrl_hold", int'(dco_control), m_ctrl);
    chk("ready_update", int'(meas_ready), 0);
    step;
    meas_valid = 1'b0;
    e = tgt - cnt;
    m_integ = clamp(m_integ + e, -IMAX, IMAX);
    m_ctrl = clamp((e >>> KP) + (m_integ >>> KI), -32768, 32767);
    m_cnt = (e <= TOL && e >= -TOL) ? (m_cnt < LC ? m_cnt + 1 : LC) : 0;
    m_locked = LD ? (m_cnt == LC) : (m_locked || m_cnt == LC);
    chk("ctrl", int'(dco_control), m_ctrl);
    chk("locked", int'(locked), int'(m_locked));
    chk("ready_back", int'(meas_ready), 1);
  endtask

  initial begin
    vecs[0] = '{1000, 900, 31, 1'b0};
    vecs[1] = '{1000, 1000, 6, 1'b0};
    vecs[2] = '{1000, 1004, 5, 1'b0};
    vecs[3] = '{1000, 997, 6, 1'b1};
    vecs[4] = '{500, 600, -26, !LD};
    vecs[5] = '{2000, 2000, -1, !LD};

    // reset state and settle timing
    rst = 1'b1;
    step;
    step;
    chk("rst_enable", int'(dco_enable), 0);
    chk("rst_ctrl", int'(dco_control), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(meas_ready), 0);
    rst = 1'b0;
    step;
    step;
    chk("idle_no_start", int'(busy), 0);
    start = 1'b1;
    step;
    chk("settle_enable", int'(dco_enable), 1);
    chk("settle_busy", int'(busy), 1);
    for (int i = 1; i < 16; i++) begin
      step;
      chk($sformatf("settle_ready_%0d", i), int'(meas_ready), 0);
    end
    step;
    chk("settle_done_ready", int'(meas_ready), 1);
    chk("settle_done_busy", int'(busy), 1);
    m_clear;

    // table-driven PI and lock vectors
    for (int i = 0; i < 6; i++) begin
      do_meas(vecs[i].tgt, vecs[i].cnt);
      chk($sformatf("vec%0d_ctrl", i), int'(dco_control), vecs[i].ctrl);
      chk($sformatf("vec%0d_locked", i), int'(locked), int'(vecs[i].lk));
    end

    // lock with {+4,-3,0}, then loss detect with +50
    do_reset;
    go_measure;
    do_meas(1004, 1000);
    do_meas(997, 1000);
    chk("lock_two", int'(locked), 0);
    do_meas(1000, 1000);
    chk("lock_three", int'(locked), 1);
    do_meas(1050, 1000);
    chk("loss_detect", int'(locked), int'(!LD));

    // +5 on the second measurement resets the count
    do_reset;
    go_measure;
    do_meas(1004, 1000);
    do_meas(1005, 1000);
    do_meas(1000, 1000);
    do_meas(997, 1000);
    chk("lock_broken", int'(locked), 0);
    do_meas(1000, 1000);
    chk("lock_after_break", int'(locked), 1);

    // abort mid-SETTLE
    do_reset;
    start = 1'b1;
    repeat (6) step;
    start = 1'b0;
    step;
    chk("abort_settle_enable", int'(dco_enable), 0);
    chk("abort_settle_busy", int'(busy), 0);

    // abort mid-UPDATE with a pending measurement, restart from a cleared integrator
    m_clear;
    go_measure;
    do_meas(1100, 1000);
    repeat (3) do_meas(1000, 1000);
    chk("pre_abort_locked", int'(locked), 1);
    chk("pre_abort_ctrl", int'(dco_control), 6);
    target = 16'd1000;
    meas_count = 16'd900;
    meas_valid = 1'b1;
    step;
    meas_valid = 1'b0;
    start = 1'b0;
    step;
    chk("abort_upd_enable", int'(dco_enable), 0);
    chk("abort_upd_ctrl", int'(dco_control), 0);
    chk("abort_upd_locked", int'(locked), 0);
    chk("abort_upd_busy", int'(busy), 0);
    m_clear;
    go_measure;
    do_meas(1000, 900);
    chk("restart_ctrl", int'(dco_control), 31);

    // asynchronous reset mid-MEASURE
    repeat (3) do_meas(1000, 1000);
    chk("pre_rst_locked", int'(locked), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ctrl", int'(dco_control), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_enable", int'(dco_enable), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(meas_ready), 0);
    start = 1'b0;
    #1;
    rst = 1'b0;
    step;
    step;
    chk("arst_stay_idle", int'(busy), 0);
    m_clear;

    // saturation up then recovery down
    go_measure;
    repeat (135) do_meas(65535, 0);
    chk("integ_sat", int'(dut.integ), IMAX);
    chk("ctrl_sat", int'(dco_control), 32767);
    repeat (130) do_meas(0, 65535);
    chk("ctrl_neg_sat", int'(dco_control), m_ctrl);

    // randomized measurements against the model
    do_reset;
    go_measure;
    for (int i = 0; i < 300; i++) begin
      int tgt, cnt;
      repeat ($urandom_range(0, 2)) begin
        meas_count = 16'($urandom);
        step;
        chk("wait_ready", int'(meas_ready), 1);
        chk("wait_ctrl", int'(dco_control), m_ctrl);
      end
      tgt = int'($urandom_range(0, 65535));
      cnt = $urandom_range(0, 1) ? clamp(tgt + int'($urandom_range(0, 12)) - 6, 0, 65535)
                                 : int'($urandom_range(0, 65535));
      do_meas(tgt, cnt);
      if ($urandom_range(0, 39) == 0) begin
        start = 1'b0;
        step;
        chk("rand_abort_busy", int'(busy), 0);
        chk("rand_abort_ctrl", int'(dco_control), 0);
        m_clear;
        go_measure;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
